// File: rtl/ffn_tile_skew_feeder.sv
// ffn_tile_skew_feeder: realigns the FFN buffer Port-B read stream, absorbs bursts in a
// small word FIFO and drives the systolic array lanes. Optional diagonal lane skew is
// enabled with the FEEDER_SKEW_EN macro (lane i delayed by i out_ready-gated stages).
// Output handshake: out_data/out_lane_valid are registered; a lane word is taken by the
// array on every cycle where out_ready=1 and the stage then advances; with out_ready=0
// the outputs hold. The fetch side cannot stall: words arriving on a full FIFO with no
// pop are dropped and flagged in the sticky overflow bit.
module ffn_tile_skew_feeder #(
  parameter int DATA_WIDTH   = 256,
  parameter int NUM_BITS     = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_THRESH = 6,
  parameter int BRAM_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               bram_en,
  input  logic [DATA_WIDTH-1:0]              doutb,
  input  logic                               fetch_done,
  input  logic                               soft_clear,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [DATA_WIDTH/NUM_BITS-1:0]     out_lane_valid,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               almost_full,
  output logic                               overflow,
  output logic                               tile_done,
  output logic                               busy
);

  localparam int LANES = DATA_WIDTH / NUM_BITS;
  localparam int PW    = $clog2(FIFO_DEPTH);
`ifdef FEEDER_SKEW_EN
  localparam int SKEW_DEPTH = LANES - 1;
`else
  localparam int SKEW_DEPTH = 0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]              state, state_nxt;
  logic [BRAM_LATENCY-1:0] en_pipe;
  logic                    wr_vld, pipe_idle, done_pend;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             level;
  logic                    fifo_empty, fifo_full, pop, push_ok, drop;
  logic [DATA_WIDTH-1:0]   base_data;
  logic                    base_vld;
  logic                    drained, flush_last;

  assign wr_vld     = en_pipe[BRAM_LATENCY-1];
  assign pipe_idle  = (en_pipe == '0);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (PW+1)'(FIFO_DEPTH));
  assign pop        = out_ready && !fifo_empty;
  assign push_ok    = wr_vld && (!fifo_full || pop);
  assign drop       = wr_vld && fifo_full && !pop;
  // Nothing left upstream of the output stage and the array takes the stage this cycle.
  assign drained    = fifo_empty && pipe_idle && !bram_en && out_ready;

  assign fifo_level  = level;
  assign almost_full = (level >= (PW+1)'(AFULL_THRESH));
  assign tile_done   = (state == S_DONE);
  assign busy        = (state != S_IDLE);

  // Delay bram_en by the BRAM read latency so wr_vld lines up with valid doutb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_pipe <= '0;
    end else if (soft_clear) begin
      en_pipe <= '0;
    end else begin
      en_pipe[0] <= bram_en;
      for (int k = 1; k < BRAM_LATENCY; k++) en_pipe[k] <= en_pipe[k-1];
    end
  end

  // FIFO storage; a write on a full FIFO only happens together with a pop of the same slot.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= doutb;
  end

  // FIFO pointers, level and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (soft_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Base output stage: next FIFO word or a bubble, advanced only when out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_data <= '0;
      base_vld  <= 1'b0;
    end else if (soft_clear) begin
      base_data <= '0;
      base_vld  <= 1'b0;
    end else if (out_ready) begin
      base_data <= fifo_empty ? '0 : mem[rd_ptr];
      base_vld  <= !fifo_empty;
    end
  end

`ifdef FEEDER_SKEW_EN
  logic [$clog2(LANES)-1:0] flush_cnt;
  assign flush_last = out_ready && (flush_cnt == ($clog2(LANES))'(SKEW_DEPTH - 1));

  // Count out_ready cycles spent in FLUSH so the deepest lane has emptied before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (soft_clear || state != S_FLUSH) begin
      flush_cnt <= '0;
    end else if (out_ready) begin
      flush_cnt <= flush_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign out_data[NUM_BITS-1:0] = base_data[NUM_BITS-1:0];
      assign out_lane_valid[0]      = base_vld;
    end else begin : g_skew
      logic [NUM_BITS-1:0] sd [i];
      logic [i-1:0]        sv;
      // Lane i delay line of i stages, advancing together with the base stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) sd[k] <= '0;
          sv <= '0;
        end else if (soft_clear) begin
          for (int k = 0; k < i; k++) sd[k] <= '0;
          sv <= '0;
        end else if (out_ready) begin
          sd[0] <= base_data[i*NUM_BITS +: NUM_BITS];
          sv[0] <= base_vld;
          for (int k = 1; k < i; k++) begin
            sd[k] <= sd[k-1];
            sv[k] <= sv[k-1];
          end
        end
      end
      assign out_data[i*NUM_BITS +: NUM_BITS] = sd[i-1];
      assign out_lane_valid[i]                = sv[i-1];
    end
  end
`else
  assign flush_last     = 1'b1;
  assign out_data       = base_data;
  assign out_lane_valid = {LANES{base_vld}};
`endif

  // done_pend remembers fetch_done until the tile completes; a new pulse wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_pend <= 1'b0;
    end else if (soft_clear) begin
      done_pend <= 1'b0;
    end else if (fetch_done) begin
      done_pend <= 1'b1;
    end else if (state == S_DONE) begin
      done_pend <= 1'b0;
    end
  end

  // Tile sequencing: stream, drain the FIFO, flush the skew lanes, then pulse tile_done.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bram_en) state_nxt = S_STREAM;
      S_STREAM: if (done_pend && pipe_idle) state_nxt = S_DRAIN;
      S_DRAIN:  if (drained) state_nxt = (SKEW_DEPTH == 0) ? S_DONE : S_FLUSH;
      S_FLUSH: begin
        if (!(fifo_empty && pipe_idle && !bram_en)) state_nxt = S_DRAIN;
        else if (flush_last)                       state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = (bram_en || !pipe_idle || !fifo_empty) ? S_STREAM : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (soft_clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_ffn_tile_skew_feeder.sv
// Testbench for ffn_tile_skew_feeder: directed steps with a word scoreboard.
module tb_ffn_tile_skew_feeder;
  localparam int DW    = 256;
  localparam int NB    = 8;
  localparam int LANES = DW / NB;
  localparam int LW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bram_en = 1'b0;
  logic             fetch_done = 1'b0;
  logic             soft_clear = 1'b0;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    doutb = '0;
  logic [DW-1:0]    rd_word = '0;
  logic [DW-1:0]    out_data;
  logic [LANES-1:0] out_lane_valid;
  logic [LW-1:0]    fifo_level;
  logic             almost_full, overflow, tile_done, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int d0;
  bit mon_en   = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] a0;

  ffn_tile_skew_feeder dut (
    .clk(clk), .rst_n(rst_n), .bram_en(bram_en), .doutb(doutb),
    .fetch_done(fetch_done), .soft_clear(soft_clear), .out_ready(out_ready),
    .out_data(out_data), .out_lane_valid(out_lane_valid), .fifo_level(fifo_level),
    .almost_full(almost_full), .overflow(overflow), .tile_done(tile_done), .busy(busy)
  );

  // clock / bram model (read latency 1)
  always #5 clk = ~clk;
  always @(posedge clk) if (bram_en) doutb <= rd_word;
  always @(negedge clk) if (tile_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // scoreboard: every word the array accepts must be the oldest expected one
  always @(negedge clk) begin
    if (mon_en && out_ready && out_lane_valid != '0) begin
      check("sb_valid_all_lanes", DW'(out_lane_valid), DW'({LANES{1'b1}}));
      check("sb_nonempty", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [DW-1:0] w, input logic fd, input bit keep);
    bram_en    = en;
    rd_word    = w;
    fetch_done = fd;
    if (en && keep) exp_q.push_back(w);
  endtask

  task automatic idle();
    bram_en    = 1'b0;
    fetch_done = 1'b0;
  endtask

  function automatic logic [DW-1:0] mkword();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic pulse_clear();
    soft_clear = 1'b1;
    tick();
    soft_clear = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]    w;
    logic [LANES-1:0] oh;
    int               exp_lvl;

    // reset state
    repeat (3) tick();
    check("rst_out_data", out_data, '0);
    check("rst_lane_valid", DW'(out_lane_valid), '0);
    check("rst_level", DW'(fifo_level), '0);
    check("rst_flags", DW'({almost_full, overflow, tile_done, busy}), '0);
    rst_n = 1'b1;
    tick();

    // async reset mid-stream with 3 words stored
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mkword(), 1'b0, 1'b0);
      tick();
    end
    idle();
    repeat (3) tick();
    check("t1_level3", DW'(fifo_level), DW'(3));
    check("t1_busy", DW'(busy), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_level", DW'(fifo_level), '0);
    check("t1_async_flags", DW'({almost_full, overflow, tile_done, busy}), '0);
    check("t1_async_valid", DW'(out_lane_valid), '0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef FEEDER_SKEW_EN
    // one diagonal word, lane i = i
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) w[i*NB +: NB] = NB'(i);
    drive(1'b1, w, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    tick();
    for (int t = 0; t < LANES; t++) begin
      oh = '0;
      oh[t] = 1'b1;
      check("t5_lane_valid", DW'(out_lane_valid), DW'(oh));
      check("t5_lane_data", DW'(out_data[t*NB +: NB]), DW'(t));
      check("t5_no_early_done", DW'(tile_done), '0);
      tick();
    end
    check("t5_tile_done", DW'(tile_done), DW'(1));
    tick();
    // same again with a 3-cycle out_ready stall during flush
    drive(1'b1, w, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    tick();
    for (int t = 0; t < LANES + 3; t++) begin
      out_ready = (t >= 10 && t < 13) ? 1'b0 : 1'b1;
      check("t5_stall_no_done", DW'(tile_done), '0);
      tick();
    end
    check("t5_stall_tile_done", DW'(tile_done), DW'(1));
    tick();
    check("t5_idle", DW'(busy), '0);
`else
    // back-to-back stream with out_ready held high
    mon_en    = 1'b1;
    out_ready = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      w = mkword();
      if (k == 0) a0 = w;
      drive(1'b1, w, (k == 3), 1'b1);
      tick();
      if (k == 1) check("t2_not_yet_valid", DW'(out_lane_valid), '0);
      if (k == 2) begin
        check("t2_latency_valid", DW'(out_lane_valid), DW'({LANES{1'b1}}));
        check("t2_latency_data", out_data, a0);
      end
    end
    idle();
    for (int i = 0; i < 30 && tile_done !== 1'b1; i++) tick();
    check("t2_tile_done_seen", DW'(tile_done), DW'(1));
    check("t2_no_early_pulse", DW'(done_cnt - d0), '0);
    check("t2_all_delivered", DW'(exp_q.size()), '0);
    check("t2_busy_in_done", DW'(busy), DW'(1));
    tick();
    check("t2_busy_falls", DW'(busy), '0);
    repeat (5) tick();
    check("t2_one_pulse", DW'(done_cnt - d0), DW'(1));

    // overflow on stalled array: 10 words into 8 entries
    out_ready = 1'b0;
    for (int j = 0; j < 13; j++) begin
      exp_lvl = (j < 2) ? 0 : ((j - 1 > 8) ? 8 : j - 1);
      check("t3_level", DW'(fifo_level), DW'(exp_lvl));
      check("t3_almost_full", DW'(almost_full), DW'(exp_lvl >= 6));
      check("t3_overflow", DW'(overflow), DW'(j >= 10));
      if (j < 10) drive(1'b1, mkword(), 1'b0, (j < 8));
      else idle();
      tick();
    end
    out_ready = 1'b1;
    repeat (12) tick();
    check("t3_drained_in_order", DW'(exp_q.size()), '0);
    check("t3_level_empty", DW'(fifo_level), '0);
    check("t3_overflow_sticky", DW'(overflow), DW'(1));
    pulse_clear();
    check("t3_overflow_cleared", DW'(overflow), '0);
    check("t3_idle_after_clear", DW'(busy), '0);

    // full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, mkword(), 1'b0, 1'b1);
      tick();
    end
    idle();
    tick();
    tick();
    check("t4_full_level", DW'(fifo_level), DW'(8));
    for (int m = 0; m < 5; m++) begin
      if (m < 4) drive(1'b1, mkword(), 1'b0, 1'b1);
      else idle();
      if (m == 1) out_ready = 1'b1;
      tick();
      check("t4_level_held", DW'(fifo_level), DW'(8));
      check("t4_no_overflow", DW'(overflow), '0);
    end
    idle();
    repeat (15) tick();
    check("t4_order_preserved", DW'(exp_q.size()), '0);
    check("t4_level_empty", DW'(fifo_level), '0);
    pulse_clear();

    // fetch_done with the last read, random array back-pressure
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive(1'b1, mkword(), (k == 2), 1'b1);
      tick();
    end
    idle();
    for (int i = 0; i < 80 && tile_done !== 1'b1; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("t6_tile_done_seen", DW'(tile_done), DW'(1));
    check("t6_no_early_pulse", DW'(done_cnt - d0), '0);
    check("t6_last_delivered", DW'(exp_q.size()), '0);
    out_ready = 1'b1;
    repeat (4) tick();
    check("t6_one_pulse", DW'(done_cnt - d0), DW'(1));
    check("t6_idle", DW'(busy), '0);
    mon_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
